// File: rtl/regwrite_trace.sv
// Register-file write trace FIFO: captures {pc, reg, data} per writeback and streams it out valid/ready.
// Optional TRACE_SKIP_R0_EN: writes to register 0 are ignored (neither traced nor counted as dropped).
`timescale 1ns/1ps

package regwrite_trace_pkg;
  typedef struct packed {
    logic [11:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } entry_t;
endpackage

module regwrite_trace
  import regwrite_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [4:0]               wr_reg,
  input  logic [31:0]              wr_data,
  input  logic [11:0]              wr_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [11:0]              out_pc,
  output logic [4:0]               out_reg,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head_q;
  entry_t             head_d;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_nxt;
  logic [FILL_W-1:0]  fill_d;
  logic               push_req;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // Push/pop decisions and the next head entry; the head is held in its own register.
  always_comb begin
    wr_entry = '{pc: wr_pc, rg: wr_reg, data: wr_data};
`ifdef TRACE_SKIP_R0_EN
    push_req = wr_en && (wr_reg != 5'd0);
`else
    push_req = wr_en;
`endif
    full   = (fill == FILL_W'(DEPTH));
    pop    = out_valid && out_ready;
    push   = push_req && (!full || pop);
    drop   = push_req && full && !pop;
    rd_nxt = rd_ptr + PTR_W'(1);
    fill_d = fill + FILL_W'(push) - FILL_W'(pop);
    head_d = head_q;
    if (pop) begin
      // A full push+pop overwrites the popped slot, never the next head
      if (fill > FILL_W'(1)) begin
        head_d = mem[rd_nxt];
      end else if (push) begin
        head_d = wr_entry;
      end
    end else if ((fill == '0) && push) begin
      head_d = wr_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      head_q    <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      fill      <= fill_d;
      out_valid <= (fill_d != '0);
      head_q    <= head_d;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign out_pc   = head_q.pc;
  assign out_reg  = head_q.rg;
  assign out_data = head_q.data;

endmodule

// File: tb/tb_regwrite_trace.sv
// Self-checking bench for regwrite_trace: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps

module tb_regwrite_trace;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] wr_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_pc;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [3:0]  fill;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  logic [48:0] q[$];
  logic [48:0] popped[$];
  int          mdrop = 0;

  regwrite_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_reg(wr_reg),
    .wr_data(wr_data), .wr_pc(wr_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_reg(out_reg),
    .out_data(out_data), .fill(fill), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    logic [48:0] h;
    chk("fill", 64'(fill), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_pc", 64'(out_pc), 64'(h[48:37]));
      chk("out_reg", 64'(out_reg), 64'(h[36:32]));
      chk("out_data", 64'(out_data), 64'(h[31:0]));
    end
  endtask

  // Called and returns at a falling edge; model mirrors the rising edge in between.
  task automatic cycle(input logic we, input logic [4:0] rg, input logic [31:0] d,
                       input logic [11:0] pc, input logic rdy);
    logic preq;
    logic full;
    logic pop;
    check_state();
    wr_en = we; wr_reg = rg; wr_data = d; wr_pc = pc; out_ready = rdy;
`ifdef TRACE_SKIP_R0_EN
    preq = we && (rg != 5'd0);
`else
    preq = we;
`endif
    full = (q.size() == DEPTH);
    pop  = rdy && (q.size() != 0);
    if (pop) popped.push_back(q.pop_front());
    if (preq) begin
      if (!full || pop) q.push_back({pc, rg, d});
      else if (mdrop != (1 << CNT_W) - 1) mdrop++;
    end
    @(negedge clock);
    wr_en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    q.delete(); popped.delete(); mdrop = 0;
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_out", {15'd0, out_pc, out_reg, out_data}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int nwr;
    logic we;
    logic [48:0] e;

    // Single write
    do_reset();
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 12'h010, 1'b0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_reg", 64'(out_reg), 64'd5);
    chk("single_data", 64'(out_data), 64'hDEADBEEF);
    chk("single_pc", 64'(out_pc), 64'h010);
    chk("single_fill", 64'(fill), 64'd1);

    // Overflow with 10 writes, then push+pop at full, then drain
    do_reset();
    for (int i = 1; i <= 10; i++) cycle(1'b1, 5'(i), 32'(i), 12'(i), 1'b0);
    chk("ovf_fill", 64'(fill), 64'd8);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    cycle(1'b1, 5'd30, 32'hA5A5_0011, 12'hABC, 1'b1);
    chk("fullpp_fill", 64'(fill), 64'd8);
    chk("fullpp_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 8; i++) cycle(1'b0, 5'd0, 32'd0, 12'd0, 1'b1);
    chk("drain_count", 64'(popped.size()), 64'd9);
    for (int i = 0; i < 8; i++) begin
      e = popped[i];
      chk("ovf_order", 64'(e[31:0]), 64'(i + 1));
    end
    e = popped[8];
    chk("fullpp_last", 64'(e[31:0]), 64'hA5A5_0011);

    // Push+pop at fill=1
    do_reset();
    cycle(1'b1, 5'd1, 32'h11, 12'h1, 1'b0);
    cycle(1'b1, 5'd2, 32'h22, 12'h2, 1'b1);
    chk("pp1_fill", 64'(fill), 64'd1);
    chk("pp1_data", 64'(out_data), 64'h22);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 270; i++) cycle(1'b1, 5'd7, $urandom, 12'(i), 1'b0);
    chk("sat_drop", 64'(drop_cnt), 64'd255);

    // Random traffic with backpressure
    do_reset();
    nwr = 0;
    for (int c = 0; c < 2000 && nwr < 100; c++) begin
      we = 1'($urandom_range(0, 1));
      if (we) nwr++;
      cycle(we, 5'($urandom), $urandom, 12'($urandom), 1'($urandom_range(0, 1)));
    end
    chk("rand_writes", 64'(nwr), 64'd100);
    for (int c = 0; c < 20; c++) cycle(1'b0, 5'd0, 32'd0, 12'd0, 1'b1);
    chk("rand_empty", 64'(fill), 64'd0);

    // Register-0 filter
    do_reset();
    cycle(1'b1, 5'd0, 32'h1234, 12'h020, 1'b0);
`ifdef TRACE_SKIP_R0_EN
    chk("r0_fill", 64'(fill), 64'd0);
`else
    chk("r0_fill", 64'(fill), 64'd1);
`endif

    // Reset mid-stream, then first push right after release
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd3, 32'(100 + i), 12'(i), 1'b0);
    chk("mid_fill4", 64'(fill), 64'd4);
    reset = 1'b0;
    #1;
    q.delete(); mdrop = 0;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_fill", 64'(fill), 64'd0);
    chk("mid_drop", 64'(drop_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b1, 5'd9, 32'hCAFE_F00D, 12'h123, 1'b0);
    chk("post_rst_fill", 64'(fill), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'hCAFE_F00D);
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
